// File: rtl/opf_pkg.sv
// Shared types and defaults for the operand fetch stage.
// The optional writeback snoop is enabled by defining OPF_WB_SNOOP_EN.
package opf_pkg;

  localparam int REG_COUNT     = 16;
  localparam int OPF_DATA_W    = 32;
  localparam int OPF_REG_NUM_W = $clog2(REG_COUNT);
  localparam int OPF_CTRL_W    = 16;

  // IDLE: waiting for decode; READ_A/READ_B: driving rs1/rs2 onto the
  // shared register-file port; HOLD: operands presented to execute.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } opf_state_e;

endpackage

// File: rtl/opf_operand_reg.sv
// One captured operand: a load-enabled register cleared by reset.
// When OPF_WB_SNOOP_EN is defined, a writeback to the source register
// that arrives after capture (inside the snoop window) refreshes the value.
module opf_operand_reg
  import opf_pkg::*;
#(
  parameter int DATA_W    = OPF_DATA_W,
  parameter int REG_NUM_W = OPF_REG_NUM_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DATA_W-1:0]    load_data_i,
  input  logic                 snoop_win_i,
  input  logic                 wb_valid_i,
  input  logic [REG_NUM_W-1:0] wb_num_i,
  input  logic [REG_NUM_W-1:0] src_num_i,
  input  logic [DATA_W-1:0]    wb_data_i,
  output logic [DATA_W-1:0]    data_o
);

  logic [DATA_W-1:0] data_q;
  logic              snoop_hit;

`ifdef OPF_WB_SNOOP_EN
  // A writeback to our source register after capture supersedes the value.
  assign snoop_hit = snoop_win_i & wb_valid_i & (wb_num_i == src_num_i);
`else
  // Without snooping the operand is frozen once captured.
  logic unused_snoop;
  assign unused_snoop = ^{snoop_win_i, wb_valid_i, wb_num_i, src_num_i, wb_data_i};
  assign snoop_hit    = 1'b0;
`endif

  // Capture register: reset clears, load beats snoop (they never coincide
  // in practice since loads only happen when no writeback is present).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (snoop_hit) begin
      data_q <= wb_data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: serialises the rs1/rs2 reads through the single register
// file port, gives writeback priority on that port, and presents the
// captured operands to execute.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready of the same interface, and the
// producer holds its payload stable while valid is high and ready is low.
// Optional feature macro: OPF_WB_SNOOP_EN (writeback snoop into captured
// operands).
module operand_fetch
  import opf_pkg::*;
#(
  parameter int DATA_W    = OPF_DATA_W,
  parameter int REG_NUM_W = OPF_REG_NUM_W,
  parameter int CTRL_W    = OPF_CTRL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_NUM_W-1:0] dec_rs1,
  input  logic [REG_NUM_W-1:0] dec_rs2,
  input  logic                 dec_use_rs2,
  input  logic [CTRL_W-1:0]    dec_ctrl,
  input  logic                 wb_valid,
  input  logic [REG_NUM_W-1:0] wb_num,
  input  logic [DATA_W-1:0]    wb_data,
  output logic [REG_NUM_W-1:0] rf_num,
  output logic                 rf_we,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [DATA_W-1:0]    ex_op_a,
  output logic [DATA_W-1:0]    ex_op_b,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output opf_state_e           dbg_state
);

  opf_state_e           state_q;
  logic [REG_NUM_W-1:0] rs1_q;
  logic [REG_NUM_W-1:0] rs2_q;
  logic                 use_rs2_q;
  logic                 ex_valid_q;
  logic [CTRL_W-1:0]    ctrl_q;

  logic                 accept;
  logic                 rd_ok;
  logic                 load_a;
  logic                 load_b;
  logic [DATA_W-1:0]    load_b_data;
  logic                 snoop_a_win;
  logic                 snoop_b_win;

  assign dec_ready = (state_q == IDLE) | ((state_q == HOLD) & ex_ready);
  assign accept    = dec_valid & dec_ready;
  // A read only completes in a cycle where writeback does not own the port.
  assign rd_ok     = ~wb_valid;

  // Register-file port mux: writeback first, then the pending source read.
  always_comb begin
    rf_num   = '0;
    rf_we    = 1'b0;
    rf_wdata = wb_data;
    if (wb_valid) begin
      rf_num = wb_num;
      rf_we  = ~reset;
    end else if (state_q == READ_A) begin
      rf_num = rs1_q;
    end else if (state_q == READ_B) begin
      rf_num = rs2_q;
    end
  end

  // Operand load enables; B is zeroed when the instruction has no rs2.
  always_comb begin
    load_a      = (state_q == READ_A) & rd_ok;
    load_b      = rd_ok & (((state_q == READ_A) & ~use_rs2_q) | (state_q == READ_B));
    load_b_data = (state_q == READ_B) ? rf_rdata : '0;
    snoop_a_win = (state_q == READ_B) | (state_q == HOLD);
    snoop_b_win = (state_q == HOLD) & use_rs2_q;
  end

  // Control FSM with registered ex_valid (high exactly in HOLD) and
  // capture of the accepted instruction's indices and control bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ex_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      use_rs2_q  <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      if (accept) begin
        rs1_q     <= dec_rs1;
        rs2_q     <= dec_rs2;
        use_rs2_q <= dec_use_rs2;
        ctrl_q    <= dec_ctrl;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= READ_A;
        end
        READ_A: begin
          if (rd_ok) begin
            if (use_rs2_q) begin
              state_q <= READ_B;
            end else begin
              state_q    <= HOLD;
              ex_valid_q <= 1'b1;
            end
          end
        end
        READ_B: begin
          if (rd_ok) begin
            state_q    <= HOLD;
            ex_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (ex_ready) begin
            state_q    <= accept ? READ_A : IDLE;
            ex_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          ex_valid_q <= 1'b0;
        end
      endcase
    end
  end

  opf_operand_reg #(
    .DATA_W    (DATA_W),
    .REG_NUM_W (REG_NUM_W)
  ) u_op_a (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load_a),
    .load_data_i (rf_rdata),
    .snoop_win_i (snoop_a_win),
    .wb_valid_i  (wb_valid),
    .wb_num_i    (wb_num),
    .src_num_i   (rs1_q),
    .wb_data_i   (wb_data),
    .data_o      (ex_op_a)
  );

  opf_operand_reg #(
    .DATA_W    (DATA_W),
    .REG_NUM_W (REG_NUM_W)
  ) u_op_b (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load_b),
    .load_data_i (load_b_data),
    .snoop_win_i (snoop_b_win),
    .wb_valid_i  (wb_valid),
    .wb_num_i    (wb_num),
    .src_num_i   (rs2_q),
    .wb_data_i   (wb_data),
    .data_o      (ex_op_b)
  );

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ctrl_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;
  import opf_pkg::*;

  localparam int DATA_W    = 32;
  localparam int REG_NUM_W = 4;
  localparam int CTRL_W    = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 dec_valid = 1'b0;
  logic                 dec_ready;
  logic [REG_NUM_W-1:0] dec_rs1 = '0;
  logic [REG_NUM_W-1:0] dec_rs2 = '0;
  logic                 dec_use_rs2 = 1'b0;
  logic [CTRL_W-1:0]    dec_ctrl = '0;
  logic                 wb_valid = 1'b0;
  logic [REG_NUM_W-1:0] wb_num = '0;
  logic [DATA_W-1:0]    wb_data = '0;
  logic [REG_NUM_W-1:0] rf_num;
  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rf_rdata;
  logic                 ex_valid;
  logic                 ex_ready = 1'b1;
  logic [DATA_W-1:0]    ex_op_a;
  logic [DATA_W-1:0]    ex_op_b;
  logic [CTRL_W-1:0]    ex_ctrl;
  opf_state_e           dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] exp_q[$];

  operand_fetch #(.DATA_W(DATA_W), .REG_NUM_W(REG_NUM_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs2(dec_use_rs2), .dec_ctrl(dec_ctrl),
    .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data),
    .rf_num(rf_num), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_ctrl(ex_ctrl), .dbg_state(dbg_state)
  );

  // Clock and register file model (combinational read, write on edge).
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf_mem [REG_COUNT];
  always @(posedge clk) if (rf_we) rf_mem[rf_num] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_num];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: writeback one register through the DUT port (one cycle).
  task automatic wb_write(input logic [REG_NUM_W-1:0] num, input logic [DATA_W-1:0] data);
    wb_valid = 1'b1; wb_num = num; wb_data = data;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Driver: present an instruction until accepted; returns at the negedge
  // right after the accept edge with dec_valid dropped.
  task automatic issue(input logic [REG_NUM_W-1:0] rs1, input logic [REG_NUM_W-1:0] rs2,
                       input logic use2, input logic [CTRL_W-1:0] ctrl);
    int guard;
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs2 = use2; dec_ctrl = ctrl;
    #1;
    guard = 0;
    while (!dec_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    check("dec_ready_wait", dec_ready, 1);
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  // Wait (bounded) for ex_valid, counting edges since the accept edge.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!ex_valid && lat < 60) begin
      @(negedge clk); lat++;
    end
    check("ex_valid_wait", ex_valid, 1);
  endtask

  typedef struct {
    logic [REG_NUM_W-1:0] rs1;
    logic [REG_NUM_W-1:0] rs2;
    logic                 use2;
    logic [CTRL_W-1:0]    ctrl;
    logic [DATA_W-1:0]    exp_a;
    logic [DATA_W-1:0]    exp_b;
    int                   exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [DATA_W-1:0] exp_a, exp_b, exp_snoop;

    vecs[0] = '{rs1: 4'd3,  rs2: 4'd7,  use2: 1'b1, ctrl: 16'h1234, exp_a: 32'h11111111, exp_b: 32'h22222222, exp_lat: 3};
    vecs[1] = '{rs1: 4'd5,  rs2: 4'd9,  use2: 1'b0, ctrl: 16'h00F0, exp_a: 32'hA5A5A5A5, exp_b: 32'h00000000, exp_lat: 2};
    vecs[2] = '{rs1: 4'd7,  rs2: 4'd3,  use2: 1'b1, ctrl: 16'hFFFF, exp_a: 32'h22222222, exp_b: 32'h11111111, exp_lat: 3};
    vecs[3] = '{rs1: 4'd0,  rs2: 4'd15, use2: 1'b1, ctrl: 16'h0001, exp_a: 32'hCAFEF00D, exp_b: 32'h80000000, exp_lat: 3};
    vecs[4] = '{rs1: 4'd15, rs2: 4'd15, use2: 1'b1, ctrl: 16'h8000, exp_a: 32'h80000000, exp_b: 32'h80000000, exp_lat: 3};
    vecs[5] = '{rs1: 4'd9,  rs2: 4'd0,  use2: 1'b0, ctrl: 16'h0000, exp_a: 32'h0F0F0F0F, exp_b: 32'h00000000, exp_lat: 2};

    // Reset block: a writeback during reset must not reach the register file.
    wb_valid = 1'b1; wb_num = 4'd1; wb_data = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("rst_rf_we", rf_we, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_op_a", ex_op_a, 0);
    check("rst_op_b", ex_op_b, 0);
    check("rst_ctrl", ex_ctrl, 0);
    wb_valid = 1'b0;
    reset = 1'b0;

    // Preload through the DUT's writeback path.
    wb_write(4'd3,  32'h11111111);
    wb_write(4'd7,  32'h22222222);
    wb_write(4'd5,  32'hA5A5A5A5);
    wb_write(4'd9,  32'h0F0F0F0F);
    wb_write(4'd0,  32'hCAFEF00D);
    wb_write(4'd15, 32'h80000000);

    // Table-driven instructions, ex_ready held high (back-to-back issue).
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_a);
      exp_q.push_back(vecs[i].exp_b);
      issue(vecs[i].rs1, vecs[i].rs2, vecs[i].use2, vecs[i].ctrl);
      check("rf_num_a", rf_num, vecs[i].rs1);
      lat = 1;
      if (vecs[i].use2) begin
        @(negedge clk); lat++;
        check("rf_num_b", rf_num, vecs[i].rs2);
      end
      wait_valid(lat, lat);
      check("latency", lat, vecs[i].exp_lat);
      exp_a = exp_q.pop_front();
      exp_b = exp_q.pop_front();
      check("op_a", ex_op_a, exp_a);
      check("op_b", ex_op_b, exp_b);
      check("ctrl", ex_ctrl, vecs[i].ctrl);
    end
    @(negedge clk);

    // Writeback during READ_B: one-cycle stall, read returns the new data.
    issue(4'd3, 4'd7, 1'b1, 16'h0003);
    @(negedge clk);
    check("t3_rf_num_b", rf_num, 7);
    wb_valid = 1'b1; wb_num = 4'd7; wb_data = 32'hDEADBEEF;
    #1;
    check("t3_rf_we", rf_we, 1);
    check("t3_rf_num_wb", rf_num, 7);
    check("t3_rf_wdata", rf_wdata, 32'hDEADBEEF);
    @(negedge clk);
    wb_valid = 1'b0;
    check("t3_stall_state", dbg_state, READ_B);
    wait_valid(3, lat);
    check("t3_latency", lat, 4);
    check("t3_op_a", ex_op_a, 32'h11111111);
    check("t3_op_b", ex_op_b, 32'hDEADBEEF);
    @(negedge clk);

    // Backpressure in HOLD, then back-to-back accept on release.
    ex_ready = 1'b0;
    issue(4'd5, 4'd0, 1'b0, 16'h0ABC);
    wait_valid(1, lat);
    check("t4_latency", lat, 2);
    dec_valid = 1'b1; dec_rs1 = 4'd3; dec_rs2 = 4'd7; dec_use_rs2 = 1'b1; dec_ctrl = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_hold_valid", ex_valid, 1);
      check("t4_hold_op_a", ex_op_a, 32'hA5A5A5A5);
      check("t4_hold_op_b", ex_op_b, 32'h0);
      check("t4_hold_ctrl", ex_ctrl, 16'h0ABC);
      check("t4_hold_dec_ready", dec_ready, 0);
      @(negedge clk);
    end
    ex_ready = 1'b1;
    #1;
    check("t4_release_dec_ready", dec_ready, 1);
    @(negedge clk);
    dec_valid = 1'b0;
    check("t4_b2b_state", dbg_state, READ_A);
    check("t4_b2b_valid", ex_valid, 0);
    check("t4_b2b_ctrl", ex_ctrl, 16'h5555);
    wait_valid(1, lat);
    check("t4_b2b_latency", lat, 3);
    check("t4_b2b_op_a", ex_op_a, 32'h11111111);
    check("t4_b2b_op_b", ex_op_b, 32'hDEADBEEF);
    @(negedge clk);

    // Writeback to rs1 while the instruction sits in HOLD.
    ex_ready = 1'b0;
    issue(4'd3, 4'd7, 1'b1, 16'h0777);
    wait_valid(1, lat);
    wb_valid = 1'b1; wb_num = 4'd3; wb_data = 32'h33333333;
    @(negedge clk);
    wb_valid = 1'b0;
`ifdef OPF_WB_SNOOP_EN
    exp_snoop = 32'h33333333;
`else
    exp_snoop = 32'h11111111;
`endif
    check("t5_op_a", ex_op_a, exp_snoop);
    check("t5_op_b", ex_op_b, 32'hDEADBEEF);
    check("t5_valid", ex_valid, 1);
    ex_ready = 1'b1;
    @(negedge clk);
    check("t5_drain_state", dbg_state, IDLE);

    // Reset in READ_B drops the instruction completely.
    issue(4'd7, 4'd5, 1'b1, 16'h0C0C);
    @(negedge clk);
    check("t6_in_read_b", dbg_state, READ_B);
    reset = 1'b1;
    wb_valid = 1'b1; wb_num = 4'd2; wb_data = 32'h12345678;
    #1;
    check("t6_rst_rf_we", rf_we, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    check("t6_state", dbg_state, IDLE);
    check("t6_valid", ex_valid, 0);
    check("t6_op_a", ex_op_a, 0);
    check("t6_op_b", ex_op_b, 0);
    check("t6_ctrl", ex_ctrl, 0);
    reset = 1'b0;
    #1;
    check("t6_dec_ready", dec_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_issue_valid", ex_valid, 0);
      check("t6_no_issue_state", dbg_state, IDLE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
